// File: rtl/earom_pkg.sv
// Shared definitions for the EAROM interface: control-register mode
// encoding, FSM state type and a helper mapping a mode to its start state.
package earom_pkg;

  localparam logic [1:0] MODE_STANDBY = 2'b00;
  localparam logic [1:0] MODE_READ    = 2'b01;
  localparam logic [1:0] MODE_ERASE   = 2'b10;
  localparam logic [1:0] MODE_WRITE   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_ERASE = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  // Control register layout as written by the CPU: {MODE[1:0], CK}
  typedef struct packed {
    logic [1:0] mode;
    logic       ck;
  } ctrl_t;

  // State entered when a CK rise is seen in IDLE with the given mode
  function automatic state_t start_state(input logic [1:0] mode);
    case (mode)
      MODE_READ:  return ST_READ;
      MODE_ERASE: return ST_ERASE;
      MODE_WRITE: return ST_WRITE;
      default:    return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/earom_if_if.sv
// CPU-side bus bundle of the EAROM interface. The master side is the CPU /
// address decoder, the slave side is the earom_if block.
interface earom_cpu_if;

  logic        phi2;
  logic        rw_n;
  logic [15:0] a;
  logic [7:0]  wdata;
  logic        cs_data;
  logic        cs_ctrl;
  logic        cs_read;
  logic [7:0]  rdata;
  logic        busy;

  modport master (
    output phi2, rw_n, a, wdata, cs_data, cs_ctrl, cs_read,
    input  rdata, busy
  );

  modport slave (
    input  phi2, rw_n, a, wdata, cs_data, cs_ctrl, cs_read,
    output rdata, busy
  );

endinterface

// File: rtl/earom_mem.sv
// Non-volatile byte storage: single clock, one write port, synchronous read
// port A for the FSM and (with EAROM_HOST_PORT_EN) read port B for the host.
// Contents are deliberately never reset.
module earom_mem #(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [7:0]    rdata_a
`ifdef EAROM_HOST_PORT_EN
  ,
  input  logic [AW-1:0] raddr_b,
  output logic [7:0]    rdata_b
`endif
);

  logic [7:0] mem [2**AW];

  // Single write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // FSM read port, registered
  always_ff @(posedge clk) begin
    rdata_a <= mem[raddr_a];
  end

`ifdef EAROM_HOST_PORT_EN
  // Host read port, registered
  always_ff @(posedge clk) begin
    rdata_b <= mem[raddr_b];
  end
`endif

endmodule

// File: rtl/earom.sv
// EAROM interface top (module earom_if). CPU accesses are qualified by the
// rising edge of the registered phi2; a CK rise in the control register
// starts a read, erase or write on the latched address/data.
// Optional macro EAROM_HOST_PORT_EN adds a host load/save port on the RAM.
module earom_if
  import earom_pkg::*;
#(
  parameter int AW        = 6,
  parameter int WR_CYCLES = 16,
  parameter int RD_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset,
  earom_cpu_if.slave    bus
`ifdef EAROM_HOST_PORT_EN
  ,
  input  logic [AW-1:0] hs_addr,
  input  logic          hs_we,
  input  logic [7:0]    hs_wdata,
  output logic [7:0]    hs_rdata
`endif
);

  localparam logic [15:0] RD_LOAD = 16'(RD_CYCLES - 1);
  localparam logic [15:0] WR_LOAD = 16'(WR_CYCLES - 1);

  logic          phi2_reg;
  logic          phi2_dly_reg;
  logic          ck_prev_reg;
  ctrl_t         ctrl_reg;
  logic [AW-1:0] addr_latch_reg;
  logic [7:0]    data_latch_reg;

  state_t        state_reg;
  logic [15:0]   cnt_reg;
  logic          busy_reg;
  logic [7:0]    out_latch_reg;
  logic [AW-1:0] op_addr_reg;
  logic          wr_en_reg;
  logic [7:0]    wr_data_reg;

  logic          strobe;
  logic          ck_rise;
  logic [AW-1:0] fsm_raddr;
  logic [7:0]    fsm_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;

  // High address bits and cs_read carry no function inside this block
  logic unused_bits;
  assign unused_bits = &{1'b0, bus.a[15:AW], bus.cs_read};

  assign strobe  = phi2_reg & ~phi2_dly_reg;
  assign ck_rise = ctrl_reg.ck & ~ck_prev_reg;

  // In IDLE the RAM already looks at the current latch so a read of
  // RD_CYCLES=1 still sees valid data; afterwards it holds the sampled address
  assign fsm_raddr = (state_reg == ST_IDLE) ? addr_latch_reg : op_addr_reg;

  // CPU bus decode: phi2 edge detection, data/address latches, control register
  always_ff @(posedge clk) begin
    if (reset) begin
      phi2_reg       <= 1'b0;
      phi2_dly_reg   <= 1'b0;
      ck_prev_reg    <= 1'b0;
      ctrl_reg       <= '0;
      addr_latch_reg <= '0;
      data_latch_reg <= '0;
    end else begin
      phi2_reg     <= bus.phi2;
      phi2_dly_reg <= phi2_reg;
      ck_prev_reg  <= ctrl_reg.ck;
      if (strobe && bus.cs_data && !bus.rw_n) begin
        addr_latch_reg <= bus.a[AW-1:0];
        data_latch_reg <= bus.wdata;
      end
      if (strobe && bus.cs_ctrl && !bus.rw_n) begin
        ctrl_reg <= ctrl_t'(bus.wdata[2:0]);
      end
    end
  end

  // Operation FSM: start on CK rise in IDLE, time the operation, register outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      busy_reg      <= 1'b0;
      out_latch_reg <= '0;
      op_addr_reg   <= '0;
      wr_en_reg     <= 1'b0;
      wr_data_reg   <= '0;
    end else begin
      wr_en_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (ck_rise && ctrl_reg.mode != MODE_STANDBY) begin
            state_reg   <= start_state(ctrl_reg.mode);
            op_addr_reg <= addr_latch_reg;
            if (ctrl_reg.mode == MODE_READ) begin
              cnt_reg <= RD_LOAD;
            end else begin
              cnt_reg     <= WR_LOAD;
              busy_reg    <= 1'b1;
              wr_en_reg   <= 1'b1;
              wr_data_reg <= (ctrl_reg.mode == MODE_ERASE) ? 8'h00 : data_latch_reg;
            end
          end
        end
        ST_READ: begin
          if (cnt_reg == '0) begin
            out_latch_reg <= fsm_rdata;
            state_reg     <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg - 16'd1;
          end
        end
        ST_ERASE, ST_WRITE: begin
          if (cnt_reg == '0) begin
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg - 16'd1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Single RAM write port: the FSM commit has priority over the host
  always_comb begin
    mem_we    = wr_en_reg;
    mem_waddr = op_addr_reg;
    mem_wdata = wr_data_reg;
`ifdef EAROM_HOST_PORT_EN
    if (!wr_en_reg && hs_we) begin
      mem_we    = 1'b1;
      mem_waddr = hs_addr;
      mem_wdata = hs_wdata;
    end
`endif
  end

  earom_mem #(.AW(AW)) u_mem (
    .clk     (clk),
    .we      (mem_we),
    .waddr   (mem_waddr),
    .wdata   (mem_wdata),
    .raddr_a (fsm_raddr),
    .rdata_a (fsm_rdata)
`ifdef EAROM_HOST_PORT_EN
    ,
    .raddr_b (hs_addr),
    .rdata_b (hs_rdata)
`endif
  );

  assign bus.rdata = out_latch_reg;
  assign bus.busy  = busy_reg;

endmodule

// File: tb/tb_earom_if.sv
// Self-checking bench for earom_if: directed scenarios plus randomized
// operations compared against a byte-array model of the storage.
// Host-port checks are included when EAROM_HOST_PORT_EN is defined.
module tb_earom_if;

  localparam int AW = 6;
  localparam int WR = 16;
  localparam int RD = 2;
  localparam int HN = 32768;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  earom_cpu_if bus ();

`ifdef EAROM_HOST_PORT_EN
  logic [AW-1:0] hs_addr;
  logic          hs_we;
  logic [7:0]    hs_wdata;
  logic [7:0]    hs_rdata;
`endif

  earom_if #(.AW(AW), .WR_CYCLES(WR), .RD_CYCLES(RD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef EAROM_HOST_PORT_EN
    ,
    .hs_addr  (hs_addr),
    .hs_we    (hs_we),
    .hs_wdata (hs_wdata),
    .hs_rdata (hs_rdata)
`endif
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat   = -1;

  logic [7:0] rd_hist   [HN];
  logic       busy_hist [HN];

  logic [7:0] model_mem [2**AW];
  logic [7:0] model_out;
  int         written_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < HN) begin
      rd_hist[cyc]   <= bus.rdata;
      busy_hist[cyc] <= bus.busy;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic bus_cycle(input logic rw, input logic csd, input logic csc, input logic csr,
                           input logic [15:0] addr, input logic [7:0] d, output int t0);
    @(negedge clk);
    bus.a = addr; bus.wdata = d; bus.rw_n = rw;
    bus.cs_data = csd; bus.cs_ctrl = csc; bus.cs_read = csr;
    bus.phi2 = 1'b1;
    t0 = cyc;
    repeat (2) @(negedge clk);
    bus.phi2 = 1'b0; bus.cs_data = 1'b0; bus.cs_ctrl = 1'b0; bus.cs_read = 1'b0; bus.rw_n = 1'b1;
  endtask

  // First busy pulse at/after t0: start index, width, and number of pulses
  task automatic scan(input int t0, output int k, output int w, output int np);
    k = -1; w = 0; np = 0;
    for (int i = t0; i < cyc && i < HN; i++) begin
      if (busy_hist[i] && (i == t0 || !busy_hist[i-1])) begin
        np++;
        if (k < 0) k = i;
      end
      if (np == 1 && busy_hist[i]) w++;
    end
  endtask

  task automatic write_ctrl_go(input logic [1:0] mode, output int t0);
    int tj;
    bus_cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, {5'd0, mode, 1'b0}, tj);
    bus_cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, {5'd0, mode, 1'b1}, t0);
  endtask

  // One complete CPU operation with model update and checks
  task automatic run_op(input logic [1:0] mode, input logic [15:0] addr, input logic [7:0] d, input bit junk);
    int t0, tj, k, w, np, ai;
    logic [7:0] old_out;
    old_out = model_out;
    ai = int'(addr[AW-1:0]);
    bus_cycle(1'b0, 1'b1, 1'b0, 1'b0, addr, d, tj);
    bus_cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, {5'd0, mode, 1'b0}, tj);
    if (junk) begin
      // accesses that must leave no trace
      bus_cycle(1'b1, 1'b1, 1'b0, 1'b0, ~addr, ~d, tj);
      bus_cycle(1'b0, 1'b0, 1'b0, 1'b1, addr + 16'd1, d + 8'd1, tj);
      bus_cycle(1'b1, 1'b0, 1'b1, 1'b0, 16'h0, {5'd0, mode, 1'b1}, tj);
    end
    bus_cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, {5'd0, mode, 1'b1}, t0);
    repeat (WR + 8) @(negedge clk);
    scan(t0, k, w, np);
    if (mode == 2'b01) begin
      model_out = model_mem[ai];
      chk("rd_busy_pulses", np, 0);
      chk("rd_before_latency", rd_hist[t0+lat+RD-1], old_out);
      chk("rd_data", rd_hist[t0+lat+RD], model_out);
      $display("op read  a=%04h exp=%02h got=%02h", addr, model_out, rd_hist[t0+lat+RD]);
    end else begin
      model_mem[ai] = (mode == 2'b10) ? 8'h00 : d;
      written_q.push_back(ai);
      chk("wr_busy_pulses", np, 1);
      if (lat < 0) begin
        lat = k - t0;
        chk("wr_latency_sane", (lat > 0 && lat < 8), 1);
      end else begin
        chk("wr_latency", k - t0, lat);
      end
      chk("wr_busy_width", w, WR);
      $display("op %s a=%04h d=%02h busy_width=%0d", (mode == 2'b10) ? "erase" : "write", addr, d, w);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, tj, k, w, np;
    logic [1:0] m;
    logic [15:0] ad;
    reset = 1'b1;
    bus.phi2 = 1'b0; bus.rw_n = 1'b1; bus.a = '0; bus.wdata = '0;
    bus.cs_data = 1'b0; bus.cs_ctrl = 1'b0; bus.cs_read = 1'b0;
`ifdef EAROM_HOST_PORT_EN
    hs_addr = '0; hs_we = 1'b0; hs_wdata = '0;
`endif
    model_out = 8'h00;
    repeat (4) @(negedge clk);
    chk("reset_busy", bus.busy, 0);
    chk("reset_rdata", bus.rdata, 8'h00);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_reset_rdata", bus.rdata, 8'h00);

    // write/read round trip, then erase
    run_op(2'b11, 16'h0005, 8'hA5, 1'b0);
    run_op(2'b01, 16'h0005, 8'h00, 1'b0);
    run_op(2'b10, 16'h0005, 8'h00, 1'b0);
    run_op(2'b01, 16'h0005, 8'h00, 1'b0);

    // busy lockout: a CK rise during WRITE is neither executed nor queued
    run_op(2'b11, 16'h0007, 8'h77, 1'b0);
    bus_cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0008, 8'h88, tj);
    write_ctrl_go(2'b11, t0);
    bus_cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0007, 8'h3C, tj);
    write_ctrl_go(2'b11, tj);
    repeat (WR + 8) @(negedge clk);
    scan(t0, k, w, np);
    model_mem[8] = 8'h88;
    chk("lock_pulses", np, 1);
    chk("lock_width", w, WR);
    $display("op lockout busy_width=%0d pulses=%0d", w, np);
    run_op(2'b01, 16'h0007, 8'h00, 1'b0);
    run_op(2'b01, 16'h0008, 8'h00, 1'b0);

    // address wrap: 0x0040 aliases to 0
    run_op(2'b11, 16'h0040, 8'h5A, 1'b0);
    run_op(2'b01, 16'h0000, 8'h00, 1'b0);

    // reset in the 5th busy cycle of a write
    bus_cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0009, 8'hC3, tj);
    write_ctrl_go(2'b11, t0);
    repeat (t0 + lat + 4 - cyc) @(negedge clk);
    chk("mid_write_busy", bus.busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_abort_busy", bus.busy, 0);
    chk("rst_abort_rdata", bus.rdata, 8'h00);
    $display("op reset mid-write busy=%0b rdata=%02h", bus.busy, bus.rdata);
    reset = 1'b0;
    model_out = 8'h00;
    model_mem[9] = 8'hC3;
    repeat (2) @(negedge clk);
    run_op(2'b01, 16'h0009, 8'h00, 1'b0);
    run_op(2'b01, 16'h0008, 8'h00, 1'b0);

`ifdef EAROM_HOST_PORT_EN
    // host write collides with CPU commit on address 3: CPU wins
    bus_cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0003, 8'h22, tj);
    write_ctrl_go(2'b11, t0);
    repeat (t0 + lat - cyc) @(negedge clk);
    chk("host_commit_cycle_busy", bus.busy, 1);
    hs_addr = 6'd3; hs_wdata = 8'h11; hs_we = 1'b1;
    @(negedge clk);
    hs_we = 1'b0;
    repeat (WR + 4) @(negedge clk);
    model_mem[3] = 8'h22;
    repeat (2) @(negedge clk);
    chk("host_collision", hs_rdata, 8'h22);
    $display("op host collision a=3 hs_rdata=%02h", hs_rdata);
    hs_addr = 6'd10; hs_wdata = 8'h5E; hs_we = 1'b1;
    @(negedge clk);
    hs_we = 1'b0;
    model_mem[10] = 8'h5E;
    written_q.push_back(10);
    run_op(2'b01, 16'h000A, 8'h00, 1'b0);
    hs_addr = 6'd7;
    repeat (2) @(negedge clk);
    chk("host_read", hs_rdata, model_mem[7]);
`endif

    // randomized operations against the model
    for (int n = 0; n < 30; n++) begin
      m = 2'($urandom_range(1, 3));
      ad = 16'($urandom);
      if (m == 2'b01) begin
        ad[AW-1:0] = AW'(written_q[$urandom_range(0, written_q.size() - 1)]);
      end
      run_op(m, ad, 8'($urandom), bit'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
